// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between producers A and B.
// Bursts of up to BURST words per grant, with saturating per-producer word counters.
module fifo_wr_arbiter #(
  parameter int B     = 8,
  parameter int BURST = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic [B-1:0]  data_a,
  output logic          ack_a,
  input  logic          req_b,
  input  logic [B-1:0]  data_b,
  output logic          ack_b,
  input  logic          fifo_full,
  output logic          fifo_wr,
  output logic [B-1:0]  fifo_w_data,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
);

  localparam int BCW = $clog2(BURST) + 1;
  localparam logic [BCW-1:0] BLAST = BCW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_A,
    SERVE_B
  } state_e;

  state_e        state_q, state_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic          last_b_q, last_b_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d;
  logic [CW-1:0] cnt_b_q, cnt_b_d;
  logic          serve_a, serve_b;

  assign serve_a = (state_q == SERVE_A);
  assign serve_b = (state_q == SERVE_B);
  assign gnt_a   = serve_a;
  assign gnt_b   = serve_b;
  assign cnt_a   = cnt_a_q;
  assign cnt_b   = cnt_b_q;

  // Reset gates the strobe so a word presented in the reset cycle is dropped.
  assign fifo_wr = ~reset & ~fifo_full &
                   ((serve_a & req_a) | (serve_b & req_b));
  assign ack_a   = fifo_wr & serve_a;
  assign ack_b   = fifo_wr & serve_b;
  assign fifo_w_data = serve_b ? data_b : data_a;

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (ack_a && (cnt_a_q != '1))
      cnt_a_d = cnt_a_q + 1'b1;
    if (ack_b && (cnt_b_q != '1))
      cnt_b_d = cnt_b_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    last_b_d = last_b_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b)
          state_d = last_b_q ? SERVE_A : SERVE_B;
        else if (req_a)
          state_d = SERVE_A;
        else if (req_b)
          state_d = SERVE_B;
      end
      SERVE_A: begin
        if (!req_a) begin
          state_d  = req_b ? SERVE_B : IDLE;
          bcnt_d   = '0;
          last_b_d = 1'b0;
        end else if (!fifo_full) begin
          if (bcnt_q == BLAST) begin
            bcnt_d = '0;
            if (req_b) begin
              state_d  = SERVE_B;
              last_b_d = 1'b0;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      SERVE_B: begin
        if (!req_b) begin
          state_d  = req_a ? SERVE_A : IDLE;
          bcnt_d   = '0;
          last_b_d = 1'b1;
        end else if (!fifo_full) begin
          if (bcnt_q == BLAST) begin
            bcnt_d = '0;
            if (req_a) begin
              state_d  = SERVE_A;
              last_b_d = 1'b1;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bcnt_q   <= '0;
      last_b_q <= 1'b1;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      last_b_q <= last_b_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, ack-pattern sequences
// and random traffic against a word-counting reference model.
module tb_fifo_wr_arbiter;

  localparam int B     = 8;
  localparam int BURST = 4;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_a = 1'b0, req_b = 1'b0, fifo_full = 1'b0;
  logic [B-1:0]  data_a = '0, data_b = '0;
  logic          ack_a, ack_b, fifo_wr, gnt_a, gnt_b;
  logic [B-1:0]  fifo_w_data;
  logic [CW-1:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.B(B), .BURST(BURST), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_w_data(fifo_w_data),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  int    checks = 0;
  int    errors = 0;
  string pat;

  // Reference: owner -1 none, 0 A, 1 B; run = words in current burst.
  int         m_own, m_run, m_prev;
  int         m_cnt[2];
  logic       s_rst, s_ew;
  logic [1:0] s_rq;

  typedef struct {
    logic       rst, ra;
    logic [7:0] da;
    logic       rb;
    logic [7:0] db;
    logic       full;
    logic       e_wr, e_aa, e_ab, e_ga, e_gb;
    logic [7:0] e_dat;
    logic [3:0] e_ca;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(string name, string act, string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_run = 0; m_prev = 1;
    m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  task automatic drive(input logic rst, input logic ra, input logic [7:0] da,
                       input logic rb, input logic [7:0] db, input logic full);
    string c;
    reset = rst; req_a = ra; data_a = da;
    req_b = rb; data_b = db; fifo_full = full;
    s_rst = rst; s_rq = {rb, ra};
    @(negedge clk);
    s_ew = !rst && !full && (m_own >= 0) && s_rq[m_own];
    chk("fifo_wr", 32'(fifo_wr), 32'(s_ew));
    chk("ack_a", 32'(ack_a), 32'(s_ew && m_own == 0));
    chk("ack_b", 32'(ack_b), 32'(s_ew && m_own == 1));
    chk("gnt_a", 32'(gnt_a), 32'(m_own == 0));
    chk("gnt_b", 32'(gnt_b), 32'(m_own == 1));
    chk("cnt_a", 32'(cnt_a), 32'(m_cnt[0]));
    chk("cnt_b", 32'(cnt_b), 32'(m_cnt[1]));
    if (s_ew)
      chk("wdata", 32'(fifo_w_data), 32'(m_own == 1 ? db : da));
    c = ack_a ? "A" : (ack_b ? "B" : "-");
    pat = {pat, c};
  endtask

  task automatic commit();
    int o;
    @(posedge clk);
    if (s_rst) begin
      model_reset();
    end else begin
      if (s_ew)
        m_cnt[m_own] = (m_cnt[m_own] == CMAX) ? CMAX : m_cnt[m_own] + 1;
      if (m_own < 0) begin
        if (s_rq[0] && s_rq[1]) m_own = (m_prev == 1) ? 0 : 1;
        else if (s_rq[0]) m_own = 0;
        else if (s_rq[1]) m_own = 1;
      end else begin
        o = 1 - m_own;
        if (!s_rq[m_own]) begin
          m_prev = m_own;
          m_run  = 0;
          m_own  = s_rq[o] ? o : -1;
        end else if (s_ew) begin
          m_run++;
          if (m_run == BURST) begin
            m_run = 0;
            if (s_rq[o]) begin
              m_prev = m_own;
              m_own  = o;
            end
          end
        end
      end
    end
    #1;
  endtask

  task automatic cyc(input logic rst, input logic ra, input logic [7:0] da,
                     input logic rb, input logic [7:0] db, input logic full);
    drive(rst, ra, da, rb, db, full);
    commit();
  endtask

  initial begin
    logic ra, rb;
    logic [7:0] da, db;
    tbl = '{
      '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0},
      '{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0},
      '{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 4'd0},
      '{1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 4'd1},
      '{1'b0, 1'b1, 8'h13, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h13, 4'd2},
      '{1'b0, 1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h14, 4'd3},
      '{1'b0, 1'b1, 8'h15, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h15, 4'd4},
      '{1'b0, 1'b1, 8'h16, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h16, 4'd5},
      '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd6},
      '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd6},
      '{1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd6},
      '{1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 4'd6},
      '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd6}
    };

    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ra, tbl[i].da, tbl[i].rb, tbl[i].db, tbl[i].full);
      chk($sformatf("tbl%0d_wr", i), 32'(fifo_wr), 32'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_acka", i), 32'(ack_a), 32'(tbl[i].e_aa));
      chk($sformatf("tbl%0d_ackb", i), 32'(ack_b), 32'(tbl[i].e_ab));
      chk($sformatf("tbl%0d_gnta", i), 32'(gnt_a), 32'(tbl[i].e_ga));
      chk($sformatf("tbl%0d_gntb", i), 32'(gnt_b), 32'(tbl[i].e_gb));
      chk($sformatf("tbl%0d_cnta", i), 32'(cnt_a), 32'(tbl[i].e_ca));
      if (tbl[i].e_wr)
        chk($sformatf("tbl%0d_data", i), 32'(fifo_w_data), 32'(tbl[i].e_dat));
      commit();
    end

    // Both requesting continuously: bursts of four, no idle between.
    cyc(1, 0, 0, 0, 0, 0);
    pat = "";
    for (int i = 0; i < 13; i++) cyc(0, 1, 8'(i), 1, 8'(8'h80 + i), 0);
    chk_str("rr_pattern", pat, "-AAAABBBBAAAA");

    // Full stall mid-burst at count 2, then finish burst and hand over.
    cyc(1, 0, 0, 0, 0, 0);
    pat = "";
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h21, 1, 8'h31, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h22, 1, 8'h31, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h23, 1, 8'h31, 0);
    chk_str("stall_pattern", pat, "-AA---AAB");

    // B alone, then A replaces B; then tie from IDLE goes to B.
    cyc(1, 0, 0, 0, 0, 0);
    pat = "";
    cyc(0, 0, 0, 1, 8'h41, 0);
    cyc(0, 0, 0, 1, 8'h41, 0);
    cyc(0, 1, 8'h42, 0, 0, 0);
    cyc(0, 1, 8'h42, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 8'h43, 1, 8'h44, 0);
    cyc(0, 1, 8'h43, 1, 8'h44, 0);
    chk_str("handover_pattern", pat, "-B-A--B");

    // Reset in SERVE_B with burst count 3.
    cyc(1, 0, 0, 0, 0, 0);
    pat = "";
    for (int i = 0; i < 8; i++) cyc(0, 1, 8'h51, 1, 8'h61, 0);
    cyc(1, 1, 8'h51, 1, 8'h61, 0);
    chk("rst_gnt_b", 32'(gnt_b), 32'd0);
    chk("rst_cnt_a", 32'(cnt_a), 32'd0);
    chk("rst_cnt_b", 32'(cnt_b), 32'd0);
    for (int i = 0; i < 2; i++) cyc(0, 1, 8'h52, 1, 8'h62, 0);
    chk_str("midrst_pattern", pat, "-AAAABBB--A");

    // Counter saturation with 20 A words.
    cyc(1, 0, 0, 0, 0, 0);
    pat = "";
    for (int i = 0; i < 21; i++) cyc(0, 1, 8'(i), 0, 0, 0);
    chk("sat_cnt_a", 32'(cnt_a), 32'd15);
    chk_str("sat_pattern", pat, {"-", {20{"A"}}});
    drive(0, 1, 8'h77, 0, 0, 0);
    chk("sat_ack_a", 32'(ack_a), 32'd1);
    commit();

    // Random traffic; requests usually held until acked.
    ra = 0; rb = 0; da = 0; db = 0;
    for (int i = 0; i < 600; i++) begin
      if (ack_a || !ra || $urandom_range(0, 9) == 0) begin
        ra = $urandom_range(0, 3) != 0;
        da = 8'($urandom);
      end
      if (ack_b || !rb || $urandom_range(0, 9) == 0) begin
        rb = $urandom_range(0, 3) != 0;
        db = 8'($urandom);
      end
      cyc($urandom_range(0, 60) == 0, ra, da, rb, db,
          $urandom_range(0, 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter sharing one FIFO write port (fifo, B-bit data) between two producers, A and B.
- Grants one producer at a time, with bursts of up to BURST words.
- Passes the granted producer's data to the FIFO and respects the FIFO full flag.
- Returns a per-word acknowledge to each producer and keeps saturating per-producer word counters for debug display.

Parameters:
- B, 8, data width; matches the FIFO B parameter.
- BURST, 4, maximum consecutive words accepted from one producer while the other is requesting; legal range 1..255.
- CW, 16, width of the per-producer accepted-word counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_a  input  1  producer A has a valid word on data_a; held until ack_a.
- data_a  input  B  producer A write data.
- ack_a  output  1  word on data_a is written to the FIFO at this rising edge.
- req_b  input  1  producer B request; same rules as req_a.
- data_b  input  B  producer B write data.
- ack_b  output  1  producer B acknowledge.
- fifo_full  input  1  FIFO full flag.
- fifo_wr  output  1  FIFO write strobe.
- fifo_w_data  output  B  FIFO write data.
- gnt_a  output  1  registered: state is SERVE_A.
- gnt_b  output  1  registered: state is SERVE_B.
- cnt_a  output  CW  words accepted from A, saturating.
- cnt_b  output  CW  words accepted from B, saturating.

Behaviour:
- Reset: clock and reset only; synchronous, active-high. Reset wins over every other event.
- Reset values:
  - state=IDLE; gnt_a=gnt_b=0.
  - burst count=0.
  - last_served=B, so A wins the first tie.
  - cnt_a=cnt_b=0.
  - ack_a=ack_b=fifo_wr=0.
- States: IDLE, SERVE_A, SERVE_B. gnt_a/gnt_b decode the state register directly.
- Combinational outputs:
  - fifo_wr = (SERVE_A & req_a & ~fifo_full) | (SERVE_B & req_b & ~fifo_full).
  - ack_a = fifo_wr & SERVE_A; ack_b = fifo_wr & SERVE_B.
  - fifo_w_data = data_b in SERVE_B, else data_a. The value is don't-care when fifo_wr=0, but the mux must stay glitch-free relative to the state register.
- fifo_wr is never asserted while fifo_full=1, since the FIFO drops such writes.
- IDLE transitions:
  - req_a & req_b: go to SERVE_A if last_served=B, else SERVE_B.
  - Exactly one request: go to that producer's state.
  - No request: stay in IDLE.
  - No write occurs in IDLE, so first-word latency from IDLE is 1 cycle.
- SERVE_A transitions (SERVE_B is symmetric):
  - Full stall (req_a=1, fifo_full=1): stay; burst count unchanged; no ack.
  - Write with burst count = BURST-1 and req_b=1: go to SERVE_B; count=0; last_served=A.
  - Write with burst count = BURST-1 and req_b=0: stay; count=0. No forced idle.
  - Write otherwise: stay; count+1.
  - req_a=0, regardless of fifo_full: go to SERVE_B if req_b, else IDLE. Count=0; last_served=A.
- Handover rules:
  - Switching directly between SERVE_A and SERVE_B costs no idle cycle.
  - The new producer can be acked on the first cycle in its state.
- Burst count width: ceil(log2(BURST))+1 bits. BURST=1 alternates every word when both producers request.
- Counters increment on their ack and hold at 2**CW-1.
- Producer contract: req and data stay stable until ack. Dropping req before ack withdraws the word, and the arbiter then releases the grant as above.
- Reset mid-burst: the next cycle is IDLE with count 0 and last_served=B. A word presented in the reset cycle is not acked or written.

Test Plan:
- After reset, req_a=1, data_a=8'h11..8'h16 in sequence, req_b=0 → gnt_a rises 1 cycle later. Six consecutive acks with fifo_wr=1, the FIFO receives 11..16, and cnt_a=6.
- req_a=req_b=1 continuously, BURST=4, fifo_full=0 → from the first SERVE_A cycle, the ack pattern is AAAABBBBAAAA with no idle cycle between bursts.
- SERVE_A mid-burst with count 2, fifo_full forced to 1 for 3 cycles → fifo_wr=ack_a=0 and state/count held. After release, two more A words, then handover to B.
- req_b only, then req_a rises on the same cycle req_b drops → SERVE_B goes to SERVE_A next cycle and data_a is written. Then tie from IDLE after both drop and reassert → SERVE_B wins, because last_served=A.
- reset asserted for one cycle during SERVE_B with count 3 → no ack in the reset cycle. Next cycle: IDLE, gnt_b=0, counters 0. With both requesting, A is granted first.
- CW=4, req_a held 20 words → cnt_a saturates at 15 while acks continue.
